// File: rtl/kf_spike_injector.sv
// kf_spike_injector: spike-event FIFO plus fan-out expander feeding the
// router's local input port. Each popped spike is looked up in a per-neuron
// fan-out table and expanded into one flit per enabled slot, in ascending
// slot order, under a ready/valid handshake.
// Optional build macro: KF_INJ_STATS_EN adds saturating 32-bit counters
// (spikes popped, flits handed off, stall cycles) and a stat_clr input.

package kf_inj_pkg;
  localparam int KF_X_W   = 4;
  localparam int KF_Y_W   = 4;
  localparam int KF_NID_W = 8;
  localparam int KF_TS_W  = 16;

  typedef struct packed {
    logic [KF_X_W-1:0]   dest_x;
    logic [KF_Y_W-1:0]   dest_y;
    logic [KF_NID_W-1:0] dest_neuron;
    logic [KF_TS_W-1:0]  timestamp;
  } spike_flit_t;
endpackage

module kf_spike_injector
  import kf_inj_pkg::*;
#(
  parameter int NUM_NEURONS = 256,
  parameter int FANOUT_MAX  = 4,
  parameter int FIFO_DEPTH  = 16,
  parameter int TS_W        = 16,
  localparam int NID_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int SLOT_W = (FANOUT_MAX > 1) ? $clog2(FANOUT_MAX) : 1,
  localparam int PTR_W  = $clog2(FIFO_DEPTH),
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spike_valid,
  output logic              spike_ready,
  input  logic [NID_W-1:0]  spike_neuron,
  input  logic [TS_W-1:0]   spike_ts,
  input  logic              cfg_we,
  input  logic [NID_W-1:0]  cfg_neuron,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic              cfg_valid,
  input  spike_flit_t       cfg_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output spike_flit_t       out_flit,
  output logic [CNT_W-1:0]  fifo_count,
`ifdef KF_INJ_STATS_EN
  input  logic              stat_clr,
  output logic [31:0]       stat_spikes,
  output logic [31:0]       stat_flits,
  output logic [31:0]       stat_stall,
`endif
  output logic              busy
);

  localparam logic [CNT_W-1:0]  DEPTH_L = CNT_W'(FIFO_DEPTH);
  localparam logic [NID_W:0]    NUM_L   = (NID_W + 1)'(NUM_NEURONS);
  localparam logic [SLOT_W:0]   SLOTS_L = (SLOT_W + 1)'(FANOUT_MAX);

  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_EMIT} state_t;

  state_t state;

  // Spike FIFO storage and bookkeeping
  logic [NID_W-1:0] fifo_nid [FIFO_DEPTH];
  logic [TS_W-1:0]  fifo_ts  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  // Fan-out table
  logic [FANOUT_MAX-1:0] tbl_valid [NUM_NEURONS];
  spike_flit_t           tbl_tmpl  [NUM_NEURONS][FANOUT_MAX];
  logic                  cfg_ok;

  // Spike being expanded, with its latched row copy
  logic [NID_W-1:0]      cur_nid;
  logic [TS_W-1:0]       cur_ts;
  logic [FANOUT_MAX-1:0] lat_mask;
  spike_flit_t           lat_tmpl [FANOUT_MAX];

  logic                  cur_in_range;
  logic [FANOUT_MAX-1:0] row_mask;
  logic [FANOUT_MAX-1:0] rem_mask;
  logic [SLOT_W-1:0]     lk_idx;
  logic [SLOT_W-1:0]     rem_idx;

  function automatic logic [SLOT_W-1:0] lowest_idx(input logic [FANOUT_MAX-1:0] m);
    logic [SLOT_W-1:0] idx;
    idx = '0;
    for (int i = FANOUT_MAX - 1; i >= 0; i--) begin
      if (m[i]) idx = SLOT_W'(i);
    end
    return idx;
  endfunction

  function automatic spike_flit_t with_ts(input spike_flit_t t, input logic [TS_W-1:0] ts);
    spike_flit_t f;
    f           = t;
    f.timestamp = KF_TS_W'(ts);
    return f;
  endfunction

  // Full/empty decisions come only from the registered count, so a pop in
  // the same cycle never opens room for a push into a full FIFO.
  assign spike_ready = (count != DEPTH_L);
  assign push        = spike_valid && spike_ready;
  assign pop         = (state == ST_IDLE) && (count != '0);
  assign fifo_count  = count;
  assign busy        = (state != ST_IDLE) || (count != '0);

  assign cfg_ok = cfg_we && ({1'b0, cfg_neuron} < NUM_L) && ({1'b0, cfg_slot} < SLOTS_L);

  // Row lookup for the popped spike and next-slot selection during emission
  assign cur_in_range = ({1'b0, cur_nid} < NUM_L);
  assign row_mask     = cur_in_range ? tbl_valid[cur_nid] : '0;
  assign lk_idx       = lowest_idx(row_mask);
  assign rem_mask     = lat_mask & (lat_mask - FANOUT_MAX'(1));
  assign rem_idx      = lowest_idx(rem_mask);

  // FIFO pointers and occupancy
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO data write
  // NOTE: storage arrays carry no reset; pointers and valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_nid[wr_ptr] <= spike_neuron;
      fifo_ts[wr_ptr]  <= spike_ts;
    end
  end

  // Table slot-valid bits; cleared on reset so an unconfigured row emits nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) tbl_valid[i] <= '0;
    end else if (cfg_ok) begin
      tbl_valid[cfg_neuron][cfg_slot] <= cfg_valid;
    end
  end

  // Table flit templates
  always_ff @(posedge clk) begin
    if (cfg_ok) tbl_tmpl[cfg_neuron][cfg_slot] <= cfg_flit;
  end

  // Expansion FSM with registered flit output
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_flit  <= '0;
      lat_mask  <= '0;
      cur_nid   <= '0;
      cur_ts    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cur_nid <= fifo_nid[rd_ptr];
            cur_ts  <= fifo_ts[rd_ptr];
            state   <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          // The latched copy isolates the burst from later table writes.
          lat_mask <= row_mask;
          for (int i = 0; i < FANOUT_MAX; i++) lat_tmpl[i] <= tbl_tmpl[cur_nid][i];
          if (row_mask == '0) begin
            state <= ST_IDLE;
          end else begin
            out_valid <= 1'b1;
            out_flit  <= with_ts(tbl_tmpl[cur_nid][lk_idx], cur_ts);
            state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            lat_mask <= rem_mask;
            if (rem_mask == '0) begin
              out_valid <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              out_flit <= with_ts(lat_tmpl[rem_idx], cur_ts);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef KF_INJ_STATS_EN
  // Saturating activity counters; stat_clr wins over any increment
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_spikes <= '0;
      stat_flits  <= '0;
      stat_stall  <= '0;
    end else begin
      if (pop && (stat_spikes != '1)) stat_spikes <= stat_spikes + 32'd1;
      if (out_valid && out_ready && (stat_flits != '1)) stat_flits <= stat_flits + 32'd1;
      if (out_valid && !out_ready && (stat_stall != '1)) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kf_spike_injector.sv
// Self-checking bench for kf_spike_injector: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// queue-based behavioural model.
module tb_kf_spike_injector;
  import kf_inj_pkg::*;

  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spike_valid = 1'b0;
  logic        spike_ready;
  logic [7:0]  spike_neuron = '0;
  logic [15:0] spike_ts = '0;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_neuron = '0;
  logic [1:0]  cfg_slot = '0;
  logic        cfg_valid = 1'b0;
  spike_flit_t cfg_flit = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  spike_flit_t out_flit;
  logic [4:0]  fifo_count;
  logic        busy;
`ifdef KF_INJ_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_spikes, stat_flits, stat_stall;
`endif

  always #5 clk = ~clk;

  kf_spike_injector dut (
    .clk(clk), .rst(rst),
    .spike_valid(spike_valid), .spike_ready(spike_ready),
    .spike_neuron(spike_neuron), .spike_ts(spike_ts),
    .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_slot(cfg_slot),
    .cfg_valid(cfg_valid), .cfg_flit(cfg_flit),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .fifo_count(fifo_count),
`ifdef KF_INJ_STATS_EN
    .stat_clr(stat_clr), .stat_spikes(stat_spikes),
    .stat_flits(stat_flits), .stat_stall(stat_stall),
`endif
    .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic spike_flit_t mk(input int x, input int y, input int n, input int ts);
    spike_flit_t f;
    f.dest_x      = 4'(x);
    f.dest_y      = 4'(y);
    f.dest_neuron = 8'(n);
    f.timestamp   = 16'(ts);
    return f;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0]  nid;
    logic [15:0] ts;
  } spk_t;

  spk_t        mfifo[$];
  spike_flit_t mburst[$];
  bit          lk_pend = 1'b0;
  spk_t        lk;
  bit [3:0]    mvalid [256];
  spike_flit_t mtmpl  [256][4];
  int          msz;
  bit          memit;
  spike_flit_t mf;
  bit          started = 1'b0;

  // Model advances on each edge from the inputs the bench is driving.
  always @(posedge clk) begin
    if (rst) begin
      mfifo.delete();
      mburst.delete();
      lk_pend = 1'b0;
      for (int i = 0; i < 256; i++) mvalid[i] = '0;
    end else begin
      msz   = mfifo.size();
      memit = (mburst.size() > 0);
      if (lk_pend) begin
        for (int s = 0; s < 4; s++) begin
          if (mvalid[lk.nid][s]) begin
            mf = mtmpl[lk.nid][s];
            mf.timestamp = lk.ts;
            mburst.push_back(mf);
          end
        end
        lk_pend = 1'b0;
      end else if (!memit && msz > 0) begin
        lk = mfifo.pop_front();
        lk_pend = 1'b1;
      end
      if (memit && out_ready) void'(mburst.pop_front());
      if (spike_valid && msz != FD) mfifo.push_back('{spike_neuron, spike_ts});
      if (cfg_we) begin
        mvalid[cfg_neuron][cfg_slot] = cfg_valid;
        mtmpl[cfg_neuron][cfg_slot]  = cfg_flit;
      end
    end
  end

  // Record every accepted flit
  spike_flit_t hs_q[$];
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) hs_q.push_back(out_flit);
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      check("out_valid", out_valid, mburst.size() > 0);
      if (mburst.size() > 0) check("out_flit", out_flit, mburst[0]);
      check("fifo_count", fifo_count, mfifo.size());
      check("spike_ready", spike_ready, mfifo.size() != FD);
      check("busy", busy, lk_pend || mburst.size() > 0 || mfifo.size() > 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int n, input int s, input bit v, input spike_flit_t f);
    cfg_neuron = 8'(n);
    cfg_slot   = 2'(s);
    cfg_valid  = v;
    cfg_flit   = f;
    cfg_we     = 1'b1;
    step();
    cfg_we     = 1'b0;
  endtask

  task automatic spike(input int n, input int ts);
    spike_neuron = 8'(n);
    spike_ts     = 16'(ts);
    spike_valid  = 1'b1;
    step();
    spike_valid  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  int         hs0;
  bit [3:0]   pat;

  initial begin
    // Reset
    step();
    step();
    started = 1'b1;
    rst = 1'b0;
    step();
    check("rst_out_flit", out_flit, 32'h0);
    check("rst_ready", spike_ready, 1'b1);
    check("rst_busy", busy, 1'b0);

    // Two-slot fan-out, exact cycle timing
    cfg_write(5, 0, 1'b1, mk(1, 0, 7, 0));
    cfg_write(5, 2, 1'b1, mk(0, 1, 9, 0));
    out_ready = 1'b1;
    spike(5, 16'h0010);                       // now cycle 1
    check("t1_cnt_c1", fifo_count, 5'd1);
    step();                                   // cycle 2
    check("t1_valid_c2", out_valid, 1'b0);
    step();                                   // cycle 3
    check("t1_valid_c3", out_valid, 1'b1);
    check("t1_flit_c3", out_flit, mk(1, 0, 7, 16'h0010));
    step();                                   // cycle 4
    check("t1_flit_c4", out_flit, mk(0, 1, 9, 16'h0010));
    step();                                   // cycle 5
    check("t1_valid_c5", out_valid, 1'b0);
    check("t1_busy_c5", busy, 1'b0);

    // Neuron with no enabled slots
    cfg_write(3, 0, 1'b0, mk(2, 2, 2, 0));
    hs0 = hs_q.size();
    spike(3, 16'h0020);                       // cycle 1
    check("t2_busy_c1", busy, 1'b1);
    step();
    check("t2_busy_c2", busy, 1'b1);
    step();
    check("t2_busy_c3", busy, 1'b0);
    check("t2_no_flits", hs_q.size() - hs0, 0);

    // Backpressure: 20 offered, 17 accepted
    out_ready = 1'b0;
    hs0 = hs_q.size();
    for (int i = 0; i < 20; i++) begin
      spike_neuron = 8'd5;
      spike_ts     = 16'(16'h0100 + i);
      spike_valid  = 1'b1;
      step();
    end
    spike_valid = 1'b0;
    check("t3_ready_low", spike_ready, 1'b0);
    check("t3_count_full", fifo_count, 5'd16);
    check("t3_held_flit", out_flit, mk(1, 0, 7, 16'h0100));
    out_ready = 1'b1;
    wait_idle(200);
    check("t3_flit_total", hs_q.size() - hs0, 34);
    for (int j = 0; j < 17; j++) begin
      if (hs_q.size() >= hs0 + 2 * j + 2) begin
        check("t3_order_a", {hs_q[hs0 + 2 * j].dest_neuron, hs_q[hs0 + 2 * j].timestamp},
              {8'd7, 16'(16'h0100 + j)});
        check("t3_order_b", {hs_q[hs0 + 2 * j + 1].dest_neuron, hs_q[hs0 + 2 * j + 1].timestamp},
              {8'd9, 16'(16'h0100 + j)});
      end
    end

    // Four-slot fan-out under ready pattern 1,0,0,1
    for (int s = 0; s < 4; s++) cfg_write(10, s, 1'b1, mk(s, s, 40 + s, 0));
    hs0 = hs_q.size();
    spike(10, 16'h0aaa);                      // cycle 1
    step();                                   // cycle 2
    step();                                   // cycle 3
    pat = 4'b1001;
    for (int i = 0; i < 12; i++) begin
      out_ready = pat[i % 4];
      step();
    end
    out_ready = 1'b1;
    wait_idle(50);
    check("t4_flit_total", hs_q.size() - hs0, 4);
    for (int s = 0; s < 4; s++) begin
      if (hs_q.size() > hs0 + s) check("t4_slot_order", hs_q[hs0 + s].dest_neuron, 8'(40 + s));
    end

    // Rewrite of the emitting row mid-burst
    for (int s = 0; s < 3; s++) cfg_write(20, s, 1'b1, mk(0, 0, 60 + s, 0));
    out_ready = 1'b0;
    hs0 = hs_q.size();
    spike(20, 16'h0bbb);
    step();
    step();                                   // cycle 3, emitting
    cfg_write(20, 1, 1'b1, mk(3, 3, 99, 0));
    out_ready = 1'b1;
    wait_idle(50);
    spike(20, 16'h0ccc);
    wait_idle(50);
    check("t5_flit_total", hs_q.size() - hs0, 6);
    if (hs_q.size() >= hs0 + 6) begin
      check("t5_old_s1", hs_q[hs0 + 1].dest_neuron, 8'd61);
      check("t5_new_s1", hs_q[hs0 + 4].dest_neuron, 8'd99);
      check("t5_new_s2", hs_q[hs0 + 5].dest_neuron, 8'd62);
    end

    // Write and lookup of the same row in the same cycle
    cfg_write(21, 0, 1'b1, mk(0, 0, 70, 0));
    spike(21, 16'h0ddd);                      // cycle 1
    step();                                   // cycle 2, lookup
    cfg_write(21, 0, 1'b1, mk(0, 0, 71, 0));  // cycle 3
    check("t5b_valid", out_valid, 1'b1);
    check("t5b_old_row", out_flit.dest_neuron, 8'd70);
    wait_idle(20);

    // Reset during emission with five queued spikes
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      spike_neuron = 8'd5;
      spike_ts     = 16'(16'h0300 + i);
      spike_valid  = 1'b1;
      step();
    end
    spike_valid = 1'b0;
    check("t6_count5", fifo_count, 5'd5);
    check("t6_emitting", out_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_valid", out_valid, 1'b0);
    check("t6_count", fifo_count, 5'd0);
    check("t6_ready", spike_ready, 1'b1);
    check("t6_flit", out_flit, 32'h0);
    out_ready = 1'b1;
    hs0 = hs_q.size();
    spike(5, 16'h0444);
    for (int i = 0; i < 8; i++) step();
    check("t6_table_cleared", hs_q.size() - hs0, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      cfg_we       = ($urandom_range(0, 7) == 0);
      cfg_neuron   = 8'($urandom_range(0, 7));
      cfg_slot     = 2'($urandom_range(0, 3));
      cfg_valid    = ($urandom_range(0, 2) != 0);
      cfg_flit     = spike_flit_t'($urandom);
      spike_valid  = $urandom_range(0, 1);
      spike_neuron = 8'($urandom_range(0, 8));
      spike_ts     = 16'($urandom);
      out_ready    = ($urandom_range(0, 3) != 0);
      step();
    end
    cfg_we      = 1'b0;
    spike_valid = 1'b0;
    out_ready   = 1'b1;
    wait_idle(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
